uart_tx_cfg: RTL and testbench
==============================

# uart_tx_cfg

Runtime-configurable UART transmitter. It serialises one frame per request: a start bit, 1 to DBIT_MAX data bits LSB-first, an optional even/odd parity bit, and 1, 1.5 or 2 stop bits, all timed by the shared baud `s_tick` oversampling strobe. Frame format is sampled per frame, so the TX FIFO-side controller can change line settings between frames without resetting the block. It replaces the fixed-format transmitter between the TX FIFO read port and the `tx` pad.

## Interface
Parameters:
- `DBIT_MAX`, 8: maximum data bits per frame. Must be ≥ 1.
- `BIT_WIDTH`, 16: `s_tick`s per bit. Must be even and ≥ 2.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `s_tick`, in, 1: baud oversampling strobe, one `clk` wide.
- `tx_start`, in, 1: frame request.
- `tx_din`, in, DBIT_MAX: frame data.
- `dbit_sel`, in, $clog2(DBIT_MAX+1): data-bit count. Values 0 and >DBIT_MAX mean DBIT_MAX.
- `par_mode`, in, 2: parity mode. 00 none, 01 even, 10 odd, 11 none.
- `stop_sel`, in, 2: stop length. 00 one bit, 01 1.5 bits, 10 or 11 two bits.
- `tx`, out, 1: serial line. Idles high.
- `tx_busy`, out, 1: high while a frame is in progress.
- `tx_done`, out, 1: one-cycle pulse at end of frame.

## Operation
- States are IDLE, START, DATA, PARITY and STOP. All are held in a registered `cs`.
- **IDLE:**
  - On `tx_start=1`, latch `tx_din`, the effective data count, parity mode and stop length into internal registers.
  - Clear the tick counter and bit counter, then go to START.
  - `tx_start` outside IDLE is ignored. No queuing.
- **START:** after BIT_WIDTH `s_tick`s, go to DATA and clear the bit counter.
- **DATA:**
  - Each bit lasts BIT_WIDTH `s_tick`s. The shift register shifts right at each bit end.
  - After the latched count of bits, go to PARITY if parity is enabled, otherwise go to STOP.
- **PARITY:**
  - Lasts BIT_WIDTH `s_tick`s, then go to STOP.
  - Even mode sends the XOR of the sent data bits only (the latched count of LSBs). Odd mode sends the inverse.
- **STOP:**
  - Lasts BIT_WIDTH, 3·BIT_WIDTH/2 or 2·BIT_WIDTH `s_tick`s, then go to IDLE.
  - The tick counter is $clog2(2·BIT_WIDTH) bits wide.
- Counters advance only on cycles with `s_tick=1`. `s_tick` gaps stretch the frame but never corrupt it.
- `tx` is a register loaded on the same edge as the state change:
  - 1 in IDLE and STOP.
  - 0 in START.
  - Current shift-register bit 0 in DATA.
  - Latched parity bit in PARITY.
- Config input changes during a frame have no effect. `tx_din` is not required to stay stable after acceptance.

## Timing
- Reset, synchronous: if `rst_n=0` at a `clk` edge, the block goes to IDLE.
  - `tx=1`, `tx_busy=0`, `tx_done=0`.
  - All counters, the shift register and the latched config are cleared.
  - This applies mid-frame too: the line returns high on that edge.
- Start latency: `tx_start` sampled at edge k gives `tx=0` and `tx_busy=1` after edge k.
- Frame end: the final STOP tick at edge m gives `cs=IDLE`, `tx_busy=0` and `tx_done=1` for exactly the cycle after edge m.
- Back-to-back frames: `tx_start` is accepted in the same cycle `tx_done` is high, so there is zero idle time between frames.
- `tx_busy` is `cs != IDLE`, driven from a register with no combinational path from inputs.
- Frame length in `s_tick`s is BIT_WIDTH·(1 + n + p) + stop ticks, where n is the data-bit count, p is 1 with parity or 0 without, and stop ticks is as configured.

## Configuration
- Macro `UART_TX_CFG_PARITY_EN` controls parity support.
- Defined: parity logic and the PARITY state are built, and `par_mode` behaves as above.
- Undefined:
  - The `par_mode` port remains but is ignored.
  - The PARITY state is unreachable and the parity logic is not synthesised.
  - DATA always goes directly to STOP, and frames are identical to `par_mode=00`.

## Structure
- Shared package holds the following, used by the block and its testbench:
  - The `state_e` enum (IDLE, START, DATA, PARITY, STOP).
  - A `parity_e` typedef for the `par_mode` encodings.
  - A `stop_e` typedef for the `stop_sel` encodings.
- One sub-module, `uart_parity_calc`, is natural. It is combinational, takes data and bit count, and outputs even parity. The top level inverts it for odd mode.

## Test plan
- BIT_WIDTH=16, `s_tick` every cycle, 0xA5, `dbit_sel`=8, `par_mode`=00, `stop_sel`=00 → `tx` runs 0,1,0,1,0,0,1,0,1,1, 16 cycles each. `tx_done` pulses once, 160 cycles after `tx` falls.
- 0x55, `dbit_sel`=7, even then odd parity → parity bit 0 then 1. Frame is 9 bits plus stop.
- `stop_sel`=01 then 10 → stop high for 24 then 32 ticks before `tx_done`.
- `tx_start` held high continuously for 3 frames → `tx` never idles between frames. `tx_start` pulses mid-frame are ignored. Exactly 3 `tx_done` pulses.
- `s_tick` every 4th cycle, 8N1 → frame spans 640 `clk`s with correct bit values.
- `rst_n` low for 1 cycle mid-DATA → next edge gives `tx=1`, `tx_busy=0`, no `tx_done`. The next request sends a clean frame.

Source files
------------

// File: rtl/uart_tx_cfg_pkg.sv
// Shared types for the runtime-configurable UART transmitter: FSM states and
// the encodings of the par_mode and stop_sel configuration inputs.
package uart_tx_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_EVEN     = 2'b01,
    PAR_ODD      = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_e;

  typedef enum logic [1:0] {
    STOP_1     = 2'b00,
    STOP_1P5   = 2'b01,
    STOP_2     = 2'b10,
    STOP_2_ALT = 2'b11
  } stop_e;

endpackage

// File: rtl/uart_parity_calc.sv
// Even parity over the low nbits bits of data (bits at or above nbits are ignored).
module uart_parity_calc #(
  parameter int unsigned DBIT_MAX = 8
) (
  input  logic [DBIT_MAX-1:0]              data,
  input  logic [$clog2(DBIT_MAX+1)-1:0]    nbits,
  output logic                             par_even
);

  localparam int unsigned CNT_W = $clog2(DBIT_MAX + 1);

  always_comb begin
    par_even = 1'b0;
    for (int unsigned i = 0; i < DBIT_MAX; i++) begin
      if (CNT_W'(i) < nbits) par_even = par_even ^ data[i];
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter; frame format is latched per frame.
// Parity support is built only when UART_TX_CFG_PARITY_EN is defined.
module uart_tx_cfg
  import uart_tx_cfg_pkg::*;
#(
  parameter int unsigned DBIT_MAX  = 8,
  parameter int unsigned BIT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_tick,
  input  logic                          tx_start,
  input  logic [DBIT_MAX-1:0]           tx_din,
  input  logic [$clog2(DBIT_MAX+1)-1:0] dbit_sel,
  input  logic [1:0]                    par_mode,
  input  logic [1:0]                    stop_sel,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_done
);

  localparam int unsigned CNT_W  = $clog2(DBIT_MAX + 1);
  localparam int unsigned TICK_W = $clog2(2 * BIT_WIDTH);

  state_e              cs, cs_n;
  logic [TICK_W-1:0]   tick_q, tick_n;
  logic [CNT_W-1:0]    bit_q, bit_n;
  logic [CNT_W-1:0]    nbit_q, nbit_n;
  logic [DBIT_MAX-1:0] shreg_q, shreg_n;
  stop_e               stop_q, stop_n;
  logic                tx_q, tx_n;
  logic                busy_q;
  logic                done_q, done_n;

  logic [CNT_W-1:0]    dbit_eff;
  logic [TICK_W-1:0]   stop_last;
  logic                bit_end;

`ifdef UART_TX_CFG_PARITY_EN
  logic par_en_q, par_en_n;
  logic par_bit_q, par_bit_n;
  logic par_calc;

  uart_parity_calc #(.DBIT_MAX(DBIT_MAX)) u_parity (
    .data     (tx_din),
    .nbits    (dbit_eff),
    .par_even (par_calc)
  );
`else
  logic unused_par_mode;
  assign unused_par_mode = ^par_mode;
`endif

  // Out-of-range data-bit selections fall back to the maximum.
  assign dbit_eff = (dbit_sel == '0 || dbit_sel > CNT_W'(DBIT_MAX)) ? CNT_W'(DBIT_MAX) : dbit_sel;
  assign bit_end  = (tick_q == TICK_W'(BIT_WIDTH - 1));

  always_comb begin
    case (stop_q)
      STOP_1:   stop_last = TICK_W'(BIT_WIDTH - 1);
      STOP_1P5: stop_last = TICK_W'(3 * BIT_WIDTH / 2 - 1);
      default:  stop_last = TICK_W'(2 * BIT_WIDTH - 1);
    endcase
  end

  // Next-state, counters, datapath and registered line value.
  always_comb begin
    cs_n    = cs;
    tick_n  = tick_q;
    bit_n   = bit_q;
    nbit_n  = nbit_q;
    shreg_n = shreg_q;
    stop_n  = stop_q;
    tx_n    = tx_q;
    done_n  = 1'b0;
`ifdef UART_TX_CFG_PARITY_EN
    par_en_n  = par_en_q;
    par_bit_n = par_bit_q;
`endif

    case (cs)
      IDLE: begin
        tx_n = 1'b1;
        if (tx_start) begin
          shreg_n = tx_din;
          nbit_n  = dbit_eff;
          stop_n  = stop_e'(stop_sel);
`ifdef UART_TX_CFG_PARITY_EN
          par_en_n  = (par_mode == PAR_EVEN) || (par_mode == PAR_ODD);
          par_bit_n = par_calc ^ (par_mode == PAR_ODD);
`endif
          tick_n  = '0;
          bit_n   = '0;
          cs_n    = START;
          tx_n    = 1'b0;
        end
      end

      START: begin
        if (s_tick) begin
          if (bit_end) begin
            tick_n = '0;
            bit_n  = '0;
            cs_n   = DATA;
            tx_n   = shreg_q[0];
          end else begin
            tick_n = tick_q + TICK_W'(1);
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (bit_end) begin
            tick_n  = '0;
            shreg_n = shreg_q >> 1;
            if (bit_q == nbit_q - CNT_W'(1)) begin
`ifdef UART_TX_CFG_PARITY_EN
              if (par_en_q) begin
                cs_n = PARITY;
                tx_n = par_bit_q;
              end else begin
                cs_n = STOP;
                tx_n = 1'b1;
              end
`else
              cs_n = STOP;
              tx_n = 1'b1;
`endif
            end else begin
              bit_n = bit_q + CNT_W'(1);
              tx_n  = shreg_n[0];
            end
          end else begin
            tick_n = tick_q + TICK_W'(1);
          end
        end
      end

`ifdef UART_TX_CFG_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (bit_end) begin
            tick_n = '0;
            cs_n   = STOP;
            tx_n   = 1'b1;
          end else begin
            tick_n = tick_q + TICK_W'(1);
          end
        end
      end
`endif

      STOP: begin
        tx_n = 1'b1;
        if (s_tick) begin
          if (tick_q == stop_last) begin
            tick_n = '0;
            cs_n   = IDLE;
            done_n = 1'b1;
          end else begin
            tick_n = tick_q + TICK_W'(1);
          end
        end
      end

      default: begin
        cs_n = IDLE;
        tx_n = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs      <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      nbit_q  <= '0;
      shreg_q <= '0;
      stop_q  <= STOP_1;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_CFG_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      cs      <= cs_n;
      tick_q  <= tick_n;
      bit_q   <= bit_n;
      nbit_q  <= nbit_n;
      shreg_q <= shreg_n;
      stop_q  <= stop_n;
      tx_q    <= tx_n;
      busy_q  <= (cs_n != IDLE);
      done_q  <= done_n;
`ifdef UART_TX_CFG_PARITY_EN
      par_en_q  <= par_en_n;
      par_bit_q <= par_bit_n;
`endif
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: expected line waveform is built per tick
// from the frame format and compared every clock.
module tb_uart_tx_cfg;
  import uart_tx_cfg_pkg::*;

  localparam int DBIT_MAX  = 8;
  localparam int BIT_WIDTH = 16;
  localparam int SEL_W     = $clog2(DBIT_MAX + 1);
`ifdef UART_TX_CFG_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic                clk;
  logic                rst_n;
  logic                s_tick;
  logic                tx_start;
  logic [DBIT_MAX-1:0] tx_din;
  logic [SEL_W-1:0]    dbit_sel;
  logic [1:0]          par_mode;
  logic [1:0]          stop_sel;
  logic                tx;
  logic                tx_busy;
  logic                tx_done;

  int n_chk  = 0;
  int n_pass = 0;
  int done_cnt = 0;

  uart_tx_cfg #(.DBIT_MAX(DBIT_MAX), .BIT_WIDTH(BIT_WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tick   (s_tick),
    .tx_start (tx_start),
    .tx_din   (tx_din),
    .dbit_sel (dbit_sel),
    .par_mode (par_mode),
    .stop_sel (stop_sel),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (tx_done) done_cnt <= done_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int eff_bits(input int sel);
    return (sel == 0 || sel > DBIT_MAX) ? DBIT_MAX : sel;
  endfunction

  // One frame: tx_done returns at the done cycle, sampled 1 time unit after the edge.
  task automatic send_frame(input logic [7:0] d, input int sel, input int par, input int stp,
                            input int div, input bit hold, input bit noise);
    bit wave[$];
    int n, total, consumed, cyc, stop_ticks;
    bit pb;
    n = eff_bits(sel);
    wave = {};
    repeat (BIT_WIDTH) wave.push_back(1'b0);
    for (int i = 0; i < n; i++) repeat (BIT_WIDTH) wave.push_back(d[i]);
    if (PAR_EN && (par == 1 || par == 2)) begin
      pb = 1'b0;
      for (int i = 0; i < n; i++) pb ^= d[i];
      if (par == 2) pb = ~pb;
      repeat (BIT_WIDTH) wave.push_back(pb);
    end
    stop_ticks = (stp == 0) ? BIT_WIDTH : (stp == 1) ? 3 * BIT_WIDTH / 2 : 2 * BIT_WIDTH;
    repeat (stop_ticks) wave.push_back(1'b1);
    total = wave.size();

    tx_start = 1'b1;
    tx_din   = d;
    dbit_sel = SEL_W'(sel);
    par_mode = 2'(par);
    stop_sel = 2'(stp);
    s_tick   = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    check_eq("start_line", {29'd0, tx, tx_busy, tx_done}, 32'b010);

    tx_start = hold;
    tx_din   = 8'($urandom);
    dbit_sel = SEL_W'($urandom);
    par_mode = 2'($urandom);
    stop_sel = 2'($urandom);
    consumed = 0;
    cyc      = 0;
    forever begin
      s_tick = ((cyc + 1) % div == 0);
      if (noise && !hold) tx_start = ($urandom_range(0, 15) == 0);
      @(posedge clk); #1;
      cyc++;
      if (s_tick) consumed++;
      if (consumed == total) begin
        check_eq("frame_end", {29'd0, tx, tx_busy, tx_done}, 32'b101);
        check_eq("frame_len", cyc, total * div);
        break;
      end
      check_eq("frame_bit", {29'd0, tx, tx_busy, tx_done}, {29'd0, wave[consumed], 2'b10});
      if (cyc > 20000) begin
        check_eq("frame_timeout", 0, 1);
        break;
      end
    end
    tx_start = 1'b0;
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; s_tick = 1'b0; tx_start = 1'b0; tx_din = '0;
    dbit_sel = '0; par_mode = '0; stop_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_state", {29'd0, tx, tx_busy, tx_done}, 32'b100);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("idle_state", {29'd0, tx, tx_busy, tx_done}, 32'b100);

    send_frame(8'hA5, 8, 0, 0, 1, 1'b0, 1'b0);
    send_frame(8'h55, 7, 1, 0, 1, 1'b0, 1'b0);
    send_frame(8'h55, 7, 2, 0, 1, 1'b0, 1'b0);
    send_frame(8'h3C, 8, 0, 1, 1, 1'b0, 1'b0);
    send_frame(8'h3C, 8, 0, 2, 1, 1'b0, 1'b0);
    send_frame(8'hFF, 0, 1, 3, 1, 1'b0, 1'b0);
    send_frame(8'h01, 1, 2, 0, 1, 1'b0, 1'b0);

    // Held request: three back-to-back frames, then nothing more.
    @(negedge clk); #1;
    d0 = done_cnt;
    @(posedge clk); #1;
    send_frame(8'h96, 8, 0, 0, 1, 1'b1, 1'b0);
    send_frame(8'h0F, 5, 1, 1, 1, 1'b1, 1'b0);
    send_frame(8'hC3, 8, 2, 2, 1, 1'b1, 1'b0);
    @(negedge clk); #1;
    check_eq("held_done_count", done_cnt - d0, 3);
    @(posedge clk); #1;
    check_eq("held_no_extra", {31'd0, tx_busy}, 0);

    send_frame(8'h5A, 8, 0, 0, 1, 1'b0, 1'b1);
    send_frame(8'h81, 8, 0, 0, 4, 1'b0, 1'b0);

    // Reset in the middle of the third data bit.
    tx_start = 1'b1; tx_din = 8'hE7; dbit_sel = 4'd8; par_mode = 2'b01; stop_sel = 2'b00;
    s_tick = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    repeat (BIT_WIDTH * 3 + 5) @(posedge clk);
    #1;
    check_eq("pre_reset_busy", {31'd0, tx_busy}, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_reset_line", {29'd0, tx, tx_busy, tx_done}, 32'b100);
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (20) @(posedge clk);
    #1;
    check_eq("post_reset_idle", {29'd0, tx, tx_busy, tx_done}, 32'b100);
    check_eq("post_reset_no_done", done_cnt - d0, 0);
    send_frame(8'h6D, 8, 0, 0, 1, 1'b0, 1'b0);

    for (int k = 0; k < 20; k++) begin
      send_frame(8'($urandom), $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(1, 3), 1'b0, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        check_eq("gap_idle", {29'd0, tx, tx_busy, tx_done}, 32'b100);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
